// File: rtl/qu_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// qu_pipe_ctrl -- front-end pipeline sequencer for the Qu core.
//
// Generates per-stage enables and flush strobes for NUM_STAGES in-order
// stages (stage 0 = fetch). Stages come up staggered after reset and after
// every flush, freeze on back-pressure, and are flushed for FLUSH_CYCLES
// cycles on a mispredict or exception, with a one-cycle PC redirect to fetch.
//
// Optional feature: define QU_PIPE_CTRL_PERF_EN to add saturating 32-bit
// performance counters (perf_stall_cycles, perf_flushes, perf_mispredicts).
//
// Ports:
//   clk                in   system clock, rising edge
//   rst                in   synchronous active-high reset
//   stall              in   global stall, freezes every stage
//   stage_stall        in   per-stage back-pressure; bit i stalls 0..i
//   mispredict         in   branch mispredict pulse
//   mispredict_pc      in   corrected PC, valid with mispredict
//   exception          in   exception pulse (wins over mispredict)
//   exception_pc       in   handler PC, valid with exception
//   stage_en           out  per-stage enable
//   stage_flush        out  per-stage flush, all ones while flushing
//   pc_override_valid  out  one-cycle redirect strobe to fetch
//   pc_override        out  redirect PC, held until next redirect
//   busy               out  high in every state except RUN
//   state              out  FSM state (0 STARTUP, 1 RUN, 2 FLUSH, 3 REFILL)
// ---------------------------------------------------------------------------
module qu_pipe_ctrl #(
    parameter int NUM_STAGES      = 4,
    parameter int PC_WIDTH        = 32,
    parameter int STARTUP_STAGGER = 1,
    parameter int FLUSH_CYCLES    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [NUM_STAGES-1:0] stage_stall,
    input  logic                  mispredict,
    input  logic [PC_WIDTH-1:0]   mispredict_pc,
    input  logic                  exception,
    input  logic [PC_WIDTH-1:0]   exception_pc,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic                  pc_override_valid,
    output logic [PC_WIDTH-1:0]   pc_override,
    output logic                  busy,
    output logic [1:0]            state
`ifdef QU_PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flushes,
    output logic [31:0]           perf_mispredicts
`endif
);

    localparam int SEQ_MAX = NUM_STAGES * STARTUP_STAGGER;
    localparam int CNT_MAX = (SEQ_MAX > FLUSH_CYCLES) ? SEQ_MAX : FLUSH_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_REFILL  = 2'd3
    } state_t;

    state_t                cur_state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_inc;
    logic [NUM_STAGES-1:0] raw_en;
    logic [NUM_STAGES-1:0] seq_en;
    logic [NUM_STAGES-1:0] blocked;
    logic                  redirect;

    assign redirect = exception | mispredict;

    // Counter saturates so a long stagger can never wrap back to 0.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    // Start-up/refill schedule: stage i comes up once cnt reaches i*STAGGER.
    always_comb begin
        seq_en = '0;
        for (int i = 0; i < NUM_STAGES; i++)
            seq_en[i] = (int'(cnt) >= i * STARTUP_STAGGER);
    end

    // Back-pressure at stage i also holds every upstream stage, so the
    // blocking mask is a running OR from the last stage down to stage 0.
    always_comb begin
        logic acc;
        acc     = 1'b0;
        blocked = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            acc        = acc | stage_stall[i];
            blocked[i] = acc | stall;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state         <= ST_STARTUP;
            cnt               <= '0;
            raw_en            <= '0;
            pc_override_valid <= 1'b0;
            pc_override       <= '0;
        end else begin
            pc_override_valid <= 1'b0;
            if (redirect) begin
                // Redirect wins over stall and restarts an ongoing flush.
                cur_state         <= ST_FLUSH;
                cnt               <= '0;
                raw_en            <= '0;
                pc_override_valid <= 1'b1;
                pc_override       <= exception ? exception_pc : mispredict_pc;
            end else begin
                case (cur_state)
                    ST_STARTUP, ST_REFILL: begin
                        // A global stall freezes the schedule entirely.
                        if (!stall) begin
                            raw_en <= seq_en;
                            cnt    <= cnt_inc;
                            if (seq_en[NUM_STAGES-1])
                                cur_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        raw_en <= '1;
                    end
                    ST_FLUSH: begin
                        // Flush length ignores stall.
                        if (int'(cnt) >= FLUSH_CYCLES - 1) begin
                            cur_state <= ST_REFILL;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: cur_state <= ST_STARTUP;
                endcase
            end
        end
    end

    assign stage_en    = raw_en & ~blocked;
    assign stage_flush = (cur_state == ST_FLUSH) ? {NUM_STAGES{1'b1}} : '0;
    assign busy        = (cur_state != ST_RUN);
    assign state       = cur_state;

`ifdef QU_PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
            perf_mispredicts  <= '0;
        end else begin
            // In RUN all raw enables are high, so any low stage_en is stall-caused.
            if (cur_state == ST_RUN && (stall || |stage_stall) && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (redirect && perf_flushes != '1)
                perf_flushes <= perf_flushes + 32'd1;
            if (mispredict && perf_mispredicts != '1)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule
